// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one full-adder slice, time-multiplexed LSB first over DATA_WIDTH cycles.
// state | meaning
// IDLE  | ready for operands; Sum_Out/Carry_Out keep the last result
// RUN   | one bit per cycle through the slice
// DONE  | result valid, held until the consumer takes it
module serial_adder_controller #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  In_Valid_In,
  output logic                  In_Ready_Out,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  input  logic                  Carry_In,
  output logic                  Out_Valid_Out,
  input  logic                  Out_Ready_In,
  output logic [DATA_WIDTH-1:0] Sum_Out,
  output logic                  Carry_Out,
  output logic                  Busy_Out
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_sum;
  logic                  r_carry;
  logic [CW-1:0]         r_cnt;

  logic                  w_s;
  logic                  w_c;
  logic                  w_last;
  logic [DATA_WIDTH:0]   w_sum_cat;

  assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c       = (r_a[0] & r_b[0]) | (r_b[0] & r_carry) | (r_a[0] & r_carry);
  // Concatenate-then-slice keeps the sum shift legal when DATA_WIDTH is 1.
  assign w_sum_cat = {w_s, r_sum};
  assign w_last    = (r_cnt == CW'(DATA_WIDTH - 1));

  assign Sum_Out   = r_sum;
  assign Carry_Out = r_carry;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    In_Ready_Out  = 1'b0;
    Out_Valid_Out = 1'b0;
    Busy_Out      = 1'b1;
    case (r_state)
      IDLE: begin
        In_Ready_Out = 1'b1;
        Busy_Out     = 1'b0;
        if (In_Valid_In) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        Out_Valid_Out = 1'b1;
        if (Out_Ready_In) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (In_Valid_In) begin
            r_a     <= Data_A_In;
            r_b     <= Data_B_In;
            r_carry <= Carry_In;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= w_sum_cat[DATA_WIDTH:1];
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed and random checks of the bit-serial adder controller at DATA_WIDTH=8.
module tb_serial_adder_controller;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         In_Valid_In;
  logic         In_Ready_Out;
  logic [W-1:0] Data_A_In;
  logic [W-1:0] Data_B_In;
  logic         Carry_In;
  logic         Out_Valid_Out;
  logic         Out_Ready_In;
  logic [W-1:0] Sum_Out;
  logic         Carry_Out;
  logic         Busy_Out;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_prev = 0;
  int acc_gap = 0;

  serial_adder_controller #(.DATA_WIDTH(W)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .In_Valid_In   (In_Valid_In),
    .In_Ready_Out  (In_Ready_Out),
    .Data_A_In     (Data_A_In),
    .Data_B_In     (Data_B_In),
    .Carry_In      (Carry_In),
    .Out_Valid_Out (Out_Valid_Out),
    .Out_Ready_In  (Out_Ready_In),
    .Sum_Out       (Sum_Out),
    .Carry_Out     (Carry_Out),
    .Busy_Out      (Busy_Out)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (In_Valid_In && In_Ready_Out) begin
      acc_gap  = cyc - acc_prev;
      acc_prev = cyc;
    end
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Accept one operation, check the RUN window, then take the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    Data_A_In = a; Data_B_In = b; Carry_In = cin; In_Valid_In = 1'b1; Out_Ready_In = 1'b1;
    check_vec("ready_before_accept", In_Ready_Out, 1);
    tick();
    In_Valid_In = 1'b0;
    check_vec("busy_run", Busy_Out, 1);
    check_vec("ready_run", In_Ready_Out, 0);
    repeat (W - 1) tick();
    check_vec("valid_last_run", Out_Valid_Out, 0);
    tick();
    check_vec("valid_done", Out_Valid_Out, 1);
    check_vec("busy_done", Busy_Out, 1);
    check_vec("sum", Sum_Out, exp_sum);
    check_vec("cout", Carry_Out, exp_cout);
    tick();
    check_vec("ready_idle", In_Ready_Out, 1);
    check_vec("valid_idle", Out_Valid_Out, 0);
  endtask

  initial begin
    logic [W:0] exp9;
    logic [W-1:0] ra, rb;
    logic rc;

    Reset = 1'b1; In_Valid_In = 1'b0; Data_A_In = '0; Data_B_In = '0;
    Carry_In = 1'b0; Out_Ready_In = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    check_vec("rst_ready", In_Ready_Out, 1);
    check_vec("rst_valid", Out_Valid_Out, 0);
    check_vec("rst_busy", Busy_Out, 0);
    check_vec("rst_sum", Sum_Out, 0);
    check_vec("rst_cout", Carry_Out, 0);

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Back-pressure in DONE: 0x12 + 0x34 = 0x46
    Data_A_In = 8'h12; Data_B_In = 8'h34; Carry_In = 1'b0; In_Valid_In = 1'b1; Out_Ready_In = 1'b0;
    tick();
    In_Valid_In = 1'b0;
    repeat (W) tick();
    for (int i = 0; i < 5; i++) begin
      check_vec("bp_valid", Out_Valid_Out, 1);
      check_vec("bp_ready", In_Ready_Out, 0);
      check_vec("bp_sum", Sum_Out, 8'h46);
      check_vec("bp_cout", Carry_Out, 0);
      tick();
    end
    check_vec("bp_still_valid", Out_Valid_Out, 1);
    Out_Ready_In = 1'b1;
    tick();
    check_vec("bp_release_ready", In_Ready_Out, 1);
    check_vec("bp_release_valid", Out_Valid_Out, 0);

    // Operand churn during RUN is ignored: 0x0F + 0x01 + 1 = 0x11
    Data_A_In = 8'h0F; Data_B_In = 8'h01; Carry_In = 1'b1; In_Valid_In = 1'b1;
    tick();
    for (int i = 0; i < W; i++) begin
      Data_A_In = 8'hA5 ^ 8'(i); Data_B_In = 8'hC3 + 8'(i); Carry_In = ~Carry_In;
      tick();
    end
    In_Valid_In = 1'b0;
    check_vec("churn_valid", Out_Valid_Out, 1);
    check_vec("churn_sum", Sum_Out, 8'h11);
    check_vec("churn_cout", Carry_Out, 0);
    tick();
    check_vec("churn_idle", In_Ready_Out, 1);

    // Reset in the 4th RUN cycle discards the operation
    Data_A_In = 8'hAB; Data_B_In = 8'hCD; Carry_In = 1'b1; In_Valid_In = 1'b1;
    tick();
    In_Valid_In = 1'b0;
    tick(); tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_vec("midrst_ready", In_Ready_Out, 1);
    check_vec("midrst_valid", Out_Valid_Out, 0);
    check_vec("midrst_busy", Busy_Out, 0);
    check_vec("midrst_sum", Sum_Out, 0);
    check_vec("midrst_cout", Carry_Out, 0);
    repeat (W + 2) begin
      tick();
      check_vec("midrst_no_valid", Out_Valid_Out, 0);
    end
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // Back-to-back random operations with In_Valid_In held high
    Out_Ready_In = 1'b1;
    In_Valid_In  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      Data_A_In = ra; Data_B_In = rb; Carry_In = rc;
      exp9 = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      check_vec("b2b_ready", In_Ready_Out, 1);
      tick();
      if (i > 0) check_vec("b2b_gap", acc_gap, W + 2);
      Data_A_In = ~ra; Data_B_In = ~rb; Carry_In = ~rc;
      repeat (W) tick();
      check_vec("b2b_valid", Out_Valid_Out, 1);
      check_vec("b2b_result", {Carry_Out, Sum_Out}, exp9);
      tick();
    end
    In_Valid_In = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_controller.md
SERIAL_ADDER_CONTROLLER -- requirements
Module: serial_adder_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 In_Valid_In  input  1  operand request valid.
REQ-006 In_Ready_Out  output  1  controller accepts operands this cycle.
REQ-007 Data_A_In  input  DATA_WIDTH  operand A, unsigned.
REQ-008 Data_B_In  input  DATA_WIDTH  operand B, unsigned.
REQ-009 Carry_In  input  1  carry-in for the addition.
REQ-010 Out_Valid_Out  output  1  result valid.
REQ-011 Out_Ready_In  input  1  consumer accepts result.
REQ-012 Sum_Out  output  DATA_WIDTH  result sum, registered.
REQ-013 Carry_Out  output  1  final carry, registered.
REQ-014 Busy_Out  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL compute {Carry_Out, Sum_Out} = Data_A_In + Data_B_In + Carry_In using exactly one 1-bit full-adder slice (sum = a^b^c, carry = ab|bc|ac), time-multiplexed one bit per cycle, LSB first.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE: In_Ready_Out=1, Out_Valid_Out=0; on In_Valid_In & In_Ready_Out at an edge: capture A, B into shift registers, Carry_In into carry register, clear bit counter, go to RUN.
REQ-018 RUN: each cycle the slice takes A_reg[0], B_reg[0], carry_reg; at the edge A_reg/B_reg shift right one bit, slice sum shifts into Sum register MSB (register shifts right), slice carry loads carry_reg, counter increments.
REQ-019 RUN SHALL last exactly DATA_WIDTH cycles; on the edge that processes bit DATA_WIDTH-1, go to DONE with Sum_Out/Carry_Out holding the complete result.
REQ-020 DONE: Out_Valid_Out=1, In_Ready_Out=0; Sum_Out and Carry_Out SHALL stay stable while Out_Ready_In=0; on Out_Valid_Out & Out_Ready_In at an edge go to IDLE.
REQ-021 Latency: operands accepted at edge k, Out_Valid_Out high in the cycle after edge k+DATA_WIDTH; minimum spacing between accepts is DATA_WIDTH+2 cycles.
REQ-022 In_Ready_Out SHALL be 1 only in IDLE; In_Valid_In and operand inputs in RUN/DONE SHALL be ignored and SHALL NOT disturb the operation.
REQ-023 Operand inputs SHALL be sampled only at the accept edge; later changes have no effect.
REQ-024 Sum_Out/Carry_Out are meaningful only while Out_Valid_Out=1; they hold the last result in IDLE until the next RUN begins shifting.
REQ-025 DATA_WIDTH=1: RUN lasts one cycle; behaviour otherwise identical.
REQ-026 Counter width SHALL be clog2(DATA_WIDTH)+1 bits; no wrap-around occurs within one operation.
REQ-027 All outputs SHALL be driven from registers or decoded directly from FSM state; no combinational path from inputs to outputs.

Reset
REQ-028 Reset=1 at an edge SHALL force: state IDLE, In_Ready_Out=1 after the edge, Out_Valid_Out=0, Busy_Out=0, Sum_Out=0, Carry_Out=0, carry/shift registers and counter 0.
REQ-029 Reset SHALL take priority over any handshake in the same cycle; an operation interrupted in RUN or DONE SHALL be discarded with no Out_Valid_Out pulse.
REQ-030 Reset has no effect between edges (synchronous).

Verification (DATA_WIDTH=8)
REQ-031 A=0x5A, B=0x3C, Cin=0, Out_Ready_In=1 -> Out_Valid_Out high in cycle after accept+8 edges, Sum_Out=0x96, Carry_Out=0, Busy_Out high RUN..DONE.
REQ-032 A=0xFF, B=0x01, Cin=0 -> Sum_Out=0x00, Carry_Out=1; A=0xFF, B=0xFF, Cin=1 -> Sum_Out=0xFF, Carry_Out=1.
REQ-033 Back-pressure: Out_Ready_In=0 for 5 cycles in DONE -> Out_Valid_Out held 1, Sum_Out/Carry_Out stable, In_Ready_Out=0; release -> IDLE next edge.
REQ-034 In_Valid_In held 1 with changing operands during RUN -> ignored; result matches operands captured at accept edge.
REQ-035 Reset asserted in 4th RUN cycle -> after edge: IDLE, In_Ready_Out=1, Out_Valid_Out=0, Sum_Out=0, Carry_Out=0; new op 0x10+0x20+0 -> 0x30, Carry_Out=0.
REQ-036 Back-to-back requests with Out_Ready_In=1 -> accepts spaced exactly 10 cycles, every result correct against a reference model for 1000 random operand sets.
